// File: rtl/ic_pkg.sv
// Shared types and constants for the icache line-fill memory responder.
package ic_pkg;

  localparam int unsigned MEM_XID_BITS = 2;
  localparam int unsigned LINE_BITS    = 128;

  typedef struct packed {
    logic [26:4]             addr;
    logic [MEM_XID_BITS-1:0] xid;
  } ic_mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BEATS,
    RESP
  } ic_resp_state_t;

endpackage

// File: rtl/ic_req_fifo.sv
// In-order request queue for the line-fill responder; exposes the head entry,
// the address behind it and the occupancy.
module ic_req_fifo
  import ic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  ic_mem_req_t           din_i,
  output ic_mem_req_t           head_o,
  output logic [26:4]           nxt_addr_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ic_mem_req_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push    = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop     = pop_i && (count_q != '0);
  assign head_o     = mem_q[rd_q];
  assign nxt_addr_o = mem_q[wrap_inc(rd_q)].addr;
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wrap_inc(wr_q);
      if (do_pop)  rd_q <= wrap_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ic_mem_resp.sv
// Memory-side responder for icache line fills: queues requests, fetches each
// line as one narrow burst from the backing RAM and returns it with its ID.
module ic_mem_resp
  import ic_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [26:4]             ic_mem_addr,
  input  logic [MEM_XID_BITS-1:0] ic_mem_xid,
  input  logic                    ic_mem_re,
  output logic                    mem_ic_ready,
  output logic                    mem_ic_valid,
  output logic [MEM_XID_BITS-1:0] mem_ic_xid,
  output logic [LINE_BITS-1:0]    mem_ic_data,
  output logic                    ram_req,
  output logic [26:4]             ram_addr,
  input  logic                    ram_gnt,
  input  logic                    ram_rvalid,
  input  logic [DATA_W-1:0]       ram_rdata
);

  localparam int unsigned NUM_BEATS = LINE_BITS / DATA_W;
  localparam int unsigned BCNT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;

  ic_resp_state_t                     state_q;
  logic [BCNT_W-1:0]                  beat_cnt_q;
  logic [NUM_BEATS-1:0][DATA_W-1:0]   line_q;
  logic                               valid_q;
  logic                               ready_q;
  logic                               rst_q;
  logic [MEM_XID_BITS-1:0]            xid_q;
  logic [26:4]                        addr_q;

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ;
  ic_mem_req_t      head;
  ic_mem_req_t      push_req;
  logic [26:4]      nxt_addr;
  logic             accept;
  logic             pop;

  // A request is only taken if we promised room for it on the previous cycle.
  assign accept       = ic_mem_re & ready_q;
  assign pop          = (state_q == RESP);
  assign push_req     = '{addr: ic_mem_addr, xid: ic_mem_xid};
  assign occ          = {1'b0, count} + (CNT_W + 1)'(accept);
  assign mem_ic_ready = ~rst_q & (occ < (CNT_W + 1)'(DEPTH));

  ic_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept),
    .pop_i      (pop),
    .din_i      (push_req),
    .head_o     (head),
    .nxt_addr_o (nxt_addr),
    .count_o    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      line_q     <= '0;
      valid_q    <= 1'b0;
      xid_q      <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      rst_q      <= 1'b1;
    end else begin
      ready_q <= mem_ic_ready;
      rst_q   <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (count != '0) begin
            state_q <= REQ;
            addr_q  <= head.addr;
          end
        end
        REQ: begin
          if (ram_gnt) begin
            state_q    <= BEATS;
            beat_cnt_q <= '0;
          end
        end
        BEATS: begin
          if (ram_rvalid) begin
            line_q[beat_cnt_q] <= ram_rdata;
            beat_cnt_q         <= beat_cnt_q + BCNT_W'(1);
            if (beat_cnt_q == BCNT_W'(NUM_BEATS - 1)) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              xid_q   <= head.xid;
            end
          end
        end
        RESP: begin
          // Head is being popped, so the next burst targets the entry behind it.
          if (count > CNT_W'(1)) begin
            state_q <= REQ;
            addr_q  <= nxt_addr;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_req      = (state_q == REQ);
  assign ram_addr     = addr_q;
  assign mem_ic_valid = valid_q;
  assign mem_ic_xid   = xid_q;
  assign mem_ic_data  = line_q;

endmodule
